// File: rtl/hw_control_seq.sv
// Hardwired Moore control sequencer for the datapath: fetch, ALU reg/imm, branch, jump, NOP, HALT.
// Define CTRL_MEM_HANDSHAKE_EN to stall T1 on mem_rdy with a fetch timeout.
module hw_control_seq #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] opcode,
    input  logic       con,
    input  logic       mem_rdy,
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       Read,
    output logic       IRin,
    output logic       Yin,
    output logic       ZLowIn,
    output logic       ZHighIn,
    output logic       ZLowout,
    output logic       Cout,
    output logic       GRA,
    output logic       GRB,
    output logic       GRC,
    output logic       Rin,
    output logic       Rout,
    output logic       CONin,
    output logic [3:0] step,
    output logic       run,
    output logic       illegal,
    output logic       mem_err
);

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        S_DEFAULT = 4'd0,
        S_T0      = 4'd1,
        S_T1      = 4'd2,
        S_T2      = 4'd3,
        S_T3      = 4'd4,
        S_T4      = 4'd5,
        S_T5      = 4'd6,
        S_T6      = 4'd7,
        S_HALTED  = 4'd15
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic zlow_out;
        logic c_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic con_in;
    } ctrl_t;

    state_e          state_q, state_d;
    logic [OP_W-1:0] opcode_q, opcode_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [3:0]      step_q;
    logic            run_q, run_d;
    logic            illegal_q, illegal_d;
    logic            err_set;

    function automatic logic op_defined(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_BR) ||
               (op == OP_JR)  || (op == OP_NOP) || (op == OP_HALT);
    endfunction

`ifdef CTRL_MEM_HANDSHAKE_EN
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q;
`else
    logic              unused_sig;
    assign unused_sig = ^{mem_rdy, WAIT_W'(WAIT_MAX)};
`endif

    // Next-state logic; the opcode is captured as T3 is entered so T3 controls come from a register.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        err_set  = 1'b0;
`ifdef CTRL_MEM_HANDSHAKE_EN
        wait_cnt_d = wait_cnt_q;
`endif
        unique case (state_q)
            S_DEFAULT: state_d = S_T0;
            S_T0:      state_d = S_T1;
            S_T1: begin
`ifdef CTRL_MEM_HANDSHAKE_EN
                if (mem_rdy) begin
                    state_d    = S_T2;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
                    state_d    = S_HALTED;
                    err_set    = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
`else
                state_d = S_T2;
`endif
            end
            S_T2: begin
                state_d  = S_T3;
                opcode_d = opcode;
            end
            S_T3: begin
                if ((opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                    (opcode_q == OP_ADDI) || (opcode_q == OP_BR)) begin
                    state_d = S_T4;
                end else if (opcode_q == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4:     state_d = S_T5;
            S_T5:     state_d = (opcode_q == OP_BR) ? S_T6 : S_T0;
            S_T6:     state_d = S_T0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_DEFAULT;
        endcase
    end

    // Control decode for the state being entered, so every output leaves a flop.
    always_comb begin
        ctrl_d    = '0;
        run_d     = (state_d != S_HALTED);
        illegal_d = 1'b0;
        unique case (state_d)
            S_T0: begin
                ctrl_d.pc_out  = 1'b1;
                ctrl_d.mar_in  = 1'b1;
                ctrl_d.inc_pc  = 1'b1;
                ctrl_d.zlow_in = 1'b1;
            end
            S_T1: begin
                ctrl_d.zlow_out = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                illegal_d = !op_defined(opcode_d);
                if ((opcode_d == OP_ADD) || (opcode_d == OP_SUB) || (opcode_d == OP_ADDI)) begin
                    ctrl_d.grb   = 1'b1;
                    ctrl_d.r_out = 1'b1;
                    ctrl_d.y_in  = 1'b1;
                end else if (opcode_d == OP_BR) begin
                    ctrl_d.gra    = 1'b1;
                    ctrl_d.r_out  = 1'b1;
                    ctrl_d.con_in = 1'b1;
                end else if (opcode_d == OP_JR) begin
                    ctrl_d.gra   = 1'b1;
                    ctrl_d.r_out = 1'b1;
                    ctrl_d.pc_in = 1'b1;
                end
            end
            S_T4: begin
                if (opcode_d == OP_ADDI) begin
                    ctrl_d.c_out    = 1'b1;
                    ctrl_d.zlow_in  = 1'b1;
                    ctrl_d.zhigh_in = 1'b1;
                end else if (opcode_d == OP_BR) begin
                    ctrl_d.pc_out = 1'b1;
                    ctrl_d.y_in   = 1'b1;
                end else begin
                    ctrl_d.grc      = 1'b1;
                    ctrl_d.r_out    = 1'b1;
                    ctrl_d.zlow_in  = 1'b1;
                    ctrl_d.zhigh_in = 1'b1;
                end
            end
            S_T5: begin
                if (opcode_d == OP_BR) begin
                    ctrl_d.c_out    = 1'b1;
                    ctrl_d.zlow_in  = 1'b1;
                    ctrl_d.zhigh_in = 1'b1;
                end else begin
                    ctrl_d.zlow_out = 1'b1;
                    ctrl_d.gra      = 1'b1;
                    ctrl_d.r_in     = 1'b1;
                end
            end
            S_T6: begin
                ctrl_d.zlow_out = con;
                ctrl_d.pc_in    = con;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_DEFAULT;
            opcode_q  <= '0;
            ctrl_q    <= '0;
            step_q    <= 4'(S_DEFAULT);
            run_q     <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            ctrl_q    <= ctrl_d;
            step_q    <= 4'(state_d);
            run_q     <= run_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CTRL_MEM_HANDSHAKE_EN
    // Stall counter and sticky fetch-timeout flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_q | err_set;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = err_set;
`endif

    assign PCout   = ctrl_q.pc_out;
    assign PCin    = ctrl_q.pc_in;
    assign IncPC   = ctrl_q.inc_pc;
    assign MARin   = ctrl_q.mar_in;
    assign MDRin   = ctrl_q.mdr_in;
    assign MDRout  = ctrl_q.mdr_out;
    assign Read    = ctrl_q.read;
    assign IRin    = ctrl_q.ir_in;
    assign Yin     = ctrl_q.y_in;
    assign ZLowIn  = ctrl_q.zlow_in;
    assign ZHighIn = ctrl_q.zhigh_in;
    assign ZLowout = ctrl_q.zlow_out;
    assign Cout    = ctrl_q.c_out;
    assign GRA     = ctrl_q.gra;
    assign GRB     = ctrl_q.grb;
    assign GRC     = ctrl_q.grc;
    assign Rin     = ctrl_q.r_in;
    assign Rout    = ctrl_q.r_out;
    assign CONin   = ctrl_q.con_in;
    assign step    = step_q;
    assign run     = run_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_hw_control_seq.sv
// Scoreboard bench for hw_control_seq: a per-instruction timeline model queues expected
// outputs for every cycle while a monitor compares them after each rising edge.
module tb_hw_control_seq;

    localparam int unsigned WAIT_MAX_TB = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam logic [18:0] M_PCOUT   = 19'(1) << 0;
    localparam logic [18:0] M_PCIN    = 19'(1) << 1;
    localparam logic [18:0] M_INCPC   = 19'(1) << 2;
    localparam logic [18:0] M_MARIN   = 19'(1) << 3;
    localparam logic [18:0] M_MDRIN   = 19'(1) << 4;
    localparam logic [18:0] M_MDROUT  = 19'(1) << 5;
    localparam logic [18:0] M_READ    = 19'(1) << 6;
    localparam logic [18:0] M_IRIN    = 19'(1) << 7;
    localparam logic [18:0] M_YIN     = 19'(1) << 8;
    localparam logic [18:0] M_ZLOWIN  = 19'(1) << 9;
    localparam logic [18:0] M_ZHIGHIN = 19'(1) << 10;
    localparam logic [18:0] M_ZLOWOUT = 19'(1) << 11;
    localparam logic [18:0] M_COUT    = 19'(1) << 12;
    localparam logic [18:0] M_GRA     = 19'(1) << 13;
    localparam logic [18:0] M_GRB     = 19'(1) << 14;
    localparam logic [18:0] M_GRC     = 19'(1) << 15;
    localparam logic [18:0] M_RIN     = 19'(1) << 16;
    localparam logic [18:0] M_ROUT    = 19'(1) << 17;
    localparam logic [18:0] M_CONIN   = 19'(1) << 18;

    localparam logic [18:0] C_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
    localparam logic [18:0] C_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [18:0] C_T2 = M_MDROUT | M_IRIN;

    typedef struct {
        logic [3:0]  step;
        logic        run;
        logic        ill;
        logic        err;
        logic [18:0] ctrl;
        string       tag;
    } exp_t;

    logic clk, clr, con, mem_rdy;
    logic [4:0] opcode;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZLowIn, ZHighIn;
    logic ZLowout, Cout, GRA, GRB, GRC, Rin, Rout, CONin, run, illegal, mem_err;
    logic [3:0] step;
    logic [18:0] act_ctrl;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic err_m    = 1'b0;

    hw_control_seq #(.WAIT_MAX(WAIT_MAX_TB), .WAIT_W(4)) dut (
        .clk(clk), .clr(clr), .opcode(opcode), .con(con), .mem_rdy(mem_rdy),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
        .ZHighIn(ZHighIn), .ZLowout(ZLowout), .Cout(Cout), .GRA(GRA), .GRB(GRB),
        .GRC(GRC), .Rin(Rin), .Rout(Rout), .CONin(CONin), .step(step), .run(run),
        .illegal(illegal), .mem_err(mem_err)
    );

    assign act_ctrl = {CONin, Rout, Rin, GRC, GRB, GRA, Cout, ZLowout, ZHighIn, ZLowIn,
                       Yin, IRin, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_def(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_BR, OP_JR, OP_NOP, OP_HALT};
    endfunction

    function automatic int nphases(input logic [4:0] op);
        if (op inside {OP_ADD, OP_SUB, OP_ADDI}) return 3;
        if (op == OP_BR) return 4;
        return 1;
    endfunction

    // Execute-phase controls (phase 0 is T3) straight from the instruction table.
    function automatic logic [18:0] phase_mask(input logic [4:0] op, input logic cn, input int i);
        case (op)
            OP_ADD, OP_SUB:
                return (i == 0) ? (M_GRB | M_ROUT | M_YIN) :
                       (i == 1) ? (M_GRC | M_ROUT | M_ZLOWIN | M_ZHIGHIN) :
                                  (M_ZLOWOUT | M_GRA | M_RIN);
            OP_ADDI:
                return (i == 0) ? (M_GRB | M_ROUT | M_YIN) :
                       (i == 1) ? (M_COUT | M_ZLOWIN | M_ZHIGHIN) :
                                  (M_ZLOWOUT | M_GRA | M_RIN);
            OP_BR:
                return (i == 0) ? (M_GRA | M_ROUT | M_CONIN) :
                       (i == 1) ? (M_PCOUT | M_YIN) :
                       (i == 2) ? (M_COUT | M_ZLOWIN | M_ZHIGHIN) :
                       (cn ? (M_ZLOWOUT | M_PCIN) : 19'(0));
            OP_JR:   return M_GRA | M_ROUT | M_PCIN;
            default: return 19'(0);
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the following edge.
    task automatic cyc(input logic c, input logic [4:0] op, input logic cn, input logic rdy,
                       input logic [3:0] st, input logic [18:0] ctl, input logic il,
                       input string tag);
        exp_t e;
        @(negedge clk);
        clr = c; opcode = op; con = cn; mem_rdy = rdy;
        if (c) err_m = 1'b0;
        e.step = st; e.run = (st != 4'd15); e.ill = il; e.err = err_m; e.ctrl = ctl;
        e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 5'($urandom_range(0, 31)), rbit(), rbit(),
                                         4'd0, 19'(0), 1'b0, "reset");
    endtask

    task automatic do_instr(input logic [4:0] op, input logic cn, input int stalls,
                            input int abort_ph, output bit halted);
        halted = 1'b0;
        cyc(1'b0, op, cn, rbit(), 4'd1, C_T0, 1'b0, "T0");
        cyc(1'b0, op, cn, rbit(), 4'd2, C_T1, 1'b0, "T1");
`ifdef CTRL_MEM_HANDSHAKE_EN
        for (int k = 1; k <= stalls; k++) begin
            if (k == int'(WAIT_MAX_TB)) begin
                err_m = 1'b1;
                cyc(1'b0, op, cn, 1'b0, 4'd15, 19'(0), 1'b0, "timeout");
                halted = 1'b1;
                return;
            end
            cyc(1'b0, op, cn, 1'b0, 4'd2, C_T1, 1'b0, "T1 stall");
        end
        cyc(1'b0, op, cn, 1'b1, 4'd3, C_T2, 1'b0, "T2");
`else
        if (stalls < 0) halted = 1'b0;
        cyc(1'b0, op, cn, rbit(), 4'd3, C_T2, 1'b0, "T2");
`endif
        for (int i = 0; i < nphases(op); i++) begin
            if (i == abort_ph) begin
                cyc(1'b1, op, cn, rbit(), 4'd0, 19'(0), 1'b0, "abort");
                return;
            end
            cyc(1'b0, op, cn, rbit(), 4'(4 + i), phase_mask(op, cn, i),
                (i == 0) && !is_def(op), $sformatf("T%0d op=%b", 3 + i, op));
        end
        if (op == OP_HALT) begin
            cyc(1'b0, op, cn, rbit(), 4'd15, 19'(0), 1'b0, "halted");
            halted = 1'b1;
        end
    endtask

    task automatic hold_halted(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 5'($urandom_range(0, 31)), rbit(), rbit(),
                                         4'd15, 19'(0), 1'b0, "halt hold");
    endtask

    // Monitor: one expected record per rising edge once stimulus starts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({step, run, illegal, mem_err, act_ctrl} !== {e.step, e.run, e.ill, e.err, e.ctrl}) begin
                    failures++;
                    $display("FAIL %s: got step=%0d run=%b illegal=%b mem_err=%b ctrl=%05h, want step=%0d run=%b illegal=%b mem_err=%b ctrl=%05h",
                             e.tag, step, run, illegal, mem_err, act_ctrl,
                             e.step, e.run, e.ill, e.err, e.ctrl);
                end
            end
        end
    end

    initial begin
        bit h;
        int r, st, ab;
        logic [4:0] op;
        clr = 1'b1; opcode = '0; con = 1'b0; mem_rdy = 1'b0;

        do_reset(3);
        do_instr(OP_ADD, 1'b0, 0, -1, h);
        do_instr(OP_BR,  1'b1, 0, -1, h);
        do_instr(OP_BR,  1'b0, 0, -1, h);
        do_instr(OP_ADDI, 1'b0, 0, 2, h);
        do_instr(OP_SUB, 1'b1, 0, -1, h);
        do_instr(OP_JR,  1'b0, 0, -1, h);
        do_instr(OP_NOP, 1'b1, 0, -1, h);
        do_instr(5'b11111, 1'b0, 0, -1, h);
        do_instr(OP_ADDI, 1'b1, 0, -1, h);
`ifdef CTRL_MEM_HANDSHAKE_EN
        do_instr(OP_ADD, 1'b0, 5, -1, h);
        do_instr(OP_BR, 1'b1, 14, -1, h);
        do_instr(OP_ADD, 1'b0, 15, -1, h);
        hold_halted(3);
        do_reset(2);
`endif
        do_instr(OP_HALT, 1'b0, 0, -1, h);
        hold_halted(4);
        do_reset(1);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    op = OP_ADD;
                2:       op = OP_SUB;
                3, 4:    op = OP_ADDI;
                5, 6, 7: op = OP_BR;
                8:       op = OP_JR;
                9:       op = OP_NOP;
                10:      op = OP_HALT;
                default: op = 5'($urandom_range(0, 31));
            endcase
`ifdef CTRL_MEM_HANDSHAKE_EN
            st = ($urandom_range(0, 9) == 0) ? int'(WAIT_MAX_TB) : $urandom_range(0, 3);
`else
            st = 0;
`endif
            ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, nphases(op) - 1) : -1;
            do_instr(op, rbit(), st, ab, h);
            if (h) begin
                hold_halted($urandom_range(1, 3));
                do_reset($urandom_range(1, 2));
            end
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
